// File: rtl/mine_job_scheduler_pkg.sv
// Shared types and constants for the mining job scheduler:
// state encoding, report status codes and the nonce width.
package mine_sched_pkg;

   localparam int NONCE_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } schedState_t;

   typedef enum logic [1:0] {
      STATUS_NONE      = 2'b00,
      STATUS_FOUND     = 2'b01,
      STATUS_EXHAUSTED = 2'b10,
      STATUS_TIMEOUT   = 2'b11
   } txStatus_t;

   // Last nonce of a job; the addition wraps modulo 2^32 on purpose.
   function automatic logic [NONCE_W-1:0] lastNonceOf(
      input logic [NONCE_W-1:0] startNonce,
      input logic [NONCE_W-1:0] span
   );
      return startNonce + span;
   endfunction

endpackage

// File: rtl/mine_job_scheduler_if.sv
// Bundle between the scheduler (master) and the UART / miner core side (slave).
interface mine_job_scheduler_if #(
   parameter int HDR_W = 640
);
   import mine_sched_pkg::*;

   logic                 hdr_valid;
   logic [HDR_W-1:0]     hdr_in;
   logic                 core_reset;
   logic [HDR_W-1:0]     core_header;
   logic [NONCE_W-1:0]   core_nonce;
   logic                 core_found;
   logic                 tx_req;
   logic                 tx_ack;
   logic [NONCE_W-1:0]   tx_nonce;
   logic [1:0]           tx_status;
   logic                 busy;

   modport master (
      input  hdr_valid, hdr_in, core_nonce, core_found, tx_ack,
      output core_reset, core_header, tx_req, tx_nonce, tx_status, busy
   );

   modport slave (
      output hdr_valid, hdr_in, core_nonce, core_found, tx_ack,
      input  core_reset, core_header, tx_req, tx_nonce, tx_status, busy
   );

endinterface

// File: rtl/mine_job_scheduler_watchdog.sv
// RUN-state watchdog: counts enabled cycles, pulses expired at LIMIT-1.
// Only built when MINE_WATCHDOG_EN is defined.
`ifdef MINE_WATCHDOG_EN
module mine_watchdog #(
   parameter logic [31:0] LIMIT = 32'd50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expired
);
   logic [31:0] countR;

   // Cycle counter, held at zero while cleared.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         countR <= 32'd0;
      end else if (clear) begin
         countR <= 32'd0;
      end else if (enable) begin
         countR <= countR + 32'd1;
      end else begin
         countR <= countR;
      end
   end

   assign expired = enable && (countR == (LIMIT - 32'd1));

endmodule
`endif

// File: rtl/mine_job_scheduler.sv
// Job sequencer for the SHA-256 miner core: load header, supervise the nonce
// search, report one result word. MINE_WATCHDOG_EN adds the RUN watchdog.
module mine_job_scheduler
   import mine_sched_pkg::*;
#(
   parameter int          HDR_W          = 640,
   parameter logic [31:0] NONCE_SPAN     = 32'hFFFF_FFFF,
   parameter int          LOAD_CYCLES    = 2,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic                 clock,
   input  logic                 reset,
   mine_job_scheduler_if.master bus
);
   localparam logic [31:0] LOAD_LAST = 32'(LOAD_CYCLES - 1);

   schedState_t          stateR, stateD;
   logic [31:0]          loadCntR, loadCntD;
   logic [HDR_W-1:0]     headerR, headerD;
   logic [NONCE_W-1:0]   lastNonceR, lastNonceD;
   logic [HDR_W-1:0]     pendHdrR, pendHdrD;
   logic                 pendValidR, pendValidD;
   logic [NONCE_W-1:0]   txNonceR, txNonceD;
   txStatus_t            txStatusR, txStatusD;
   logic                 txReqR, busyR, coreResetR;
   logic                 runEvent;
   logic                 wdExpired;
   logic [HDR_W-1:0]     nextHdr;

`ifdef MINE_WATCHDOG_EN
   mine_watchdog #(.LIMIT(TIMEOUT_CYCLES)) uWatchdog (
      .clock   (clock),
      .reset   (reset),
      .enable  (stateR == RUN),
      .clear   (stateR != RUN),
      .expired (wdExpired)
   );
`else
   assign wdExpired = 1'b0;
`endif

   // Header that starts the next LOAD out of REPORT: a same-cycle header beats the buffered one.
   assign nextHdr = bus.hdr_valid ? bus.hdr_in : pendHdrR;

   // Next-state and job bookkeeping.
   always_comb begin
      stateD     = stateR;
      loadCntD   = loadCntR;
      headerD    = headerR;
      lastNonceD = lastNonceR;
      pendHdrD   = pendHdrR;
      pendValidD = pendValidR;
      txNonceD   = txNonceR;
      txStatusD  = txStatusR;
      runEvent   = 1'b0;
      case (stateR)
         IDLE: begin
            if (bus.hdr_valid) begin
               headerD    = bus.hdr_in;
               lastNonceD = lastNonceOf(bus.hdr_in[NONCE_W-1:0], NONCE_SPAN);
               loadCntD   = 32'd0;
               stateD     = LOAD;
            end else begin
               stateD = IDLE;
            end
         end
         LOAD: begin
            // A fresh header during LOAD simply restarts the load.
            if (bus.hdr_valid) begin
               headerD    = bus.hdr_in;
               lastNonceD = lastNonceOf(bus.hdr_in[NONCE_W-1:0], NONCE_SPAN);
               loadCntD   = 32'd0;
            end else if (loadCntR == LOAD_LAST) begin
               stateD = RUN;
            end else begin
               loadCntD = loadCntR + 32'd1;
            end
         end
         RUN: begin
            if (bus.core_found) begin
               txNonceD  = bus.core_nonce;
               txStatusD = STATUS_FOUND;
               runEvent  = 1'b1;
            end else if (bus.core_nonce == lastNonceR) begin
               txNonceD  = lastNonceR;
               txStatusD = STATUS_EXHAUSTED;
               runEvent  = 1'b1;
            end else if (wdExpired) begin
               txNonceD  = bus.core_nonce;
               txStatusD = STATUS_TIMEOUT;
               runEvent  = 1'b1;
            end else begin
               runEvent = 1'b0;
            end
            if (runEvent) begin
               stateD = REPORT;
               if (bus.hdr_valid) begin
                  pendHdrD   = bus.hdr_in;
                  pendValidD = 1'b1;
               end else begin
                  pendValidD = pendValidR;
               end
            end else if (bus.hdr_valid) begin
               headerD    = bus.hdr_in;
               lastNonceD = lastNonceOf(bus.hdr_in[NONCE_W-1:0], NONCE_SPAN);
               loadCntD   = 32'd0;
               stateD     = LOAD;
            end else begin
               stateD = RUN;
            end
         end
         REPORT: begin
            if (bus.tx_ack) begin
               pendValidD = 1'b0;
               if (pendValidR || bus.hdr_valid) begin
                  headerD    = nextHdr;
                  lastNonceD = lastNonceOf(nextHdr[NONCE_W-1:0], NONCE_SPAN);
                  loadCntD   = 32'd0;
                  stateD     = LOAD;
               end else begin
                  stateD = IDLE;
               end
            end else if (bus.hdr_valid) begin
               pendHdrD   = bus.hdr_in;
               pendValidD = 1'b1;
            end else begin
               stateD = REPORT;
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // State, job registers and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateR     <= IDLE;
         loadCntR   <= 32'd0;
         headerR    <= '0;
         lastNonceR <= 32'd0;
         pendHdrR   <= '0;
         pendValidR <= 1'b0;
         txNonceR   <= 32'd0;
         txStatusR  <= STATUS_NONE;
         txReqR     <= 1'b0;
         busyR      <= 1'b0;
         coreResetR <= 1'b1;
      end else begin
         stateR     <= stateD;
         loadCntR   <= loadCntD;
         headerR    <= headerD;
         lastNonceR <= lastNonceD;
         pendHdrR   <= pendHdrD;
         pendValidR <= pendValidD;
         txNonceR   <= txNonceD;
         txStatusR  <= txStatusD;
         txReqR     <= (stateD == REPORT);
         busyR      <= (stateD != IDLE);
         coreResetR <= (stateD != RUN);
      end
   end

   assign bus.core_reset  = coreResetR;
   assign bus.core_header = headerR;
   assign bus.tx_req      = txReqR;
   assign bus.tx_nonce    = txNonceR;
   assign bus.tx_status   = txStatusR;
   assign bus.busy        = busyR;

endmodule

// File: tb/tb_mine_job_scheduler.sv
// Self-checking bench for mine_job_scheduler: vector table of jobs plus
// hand-written preemption, pending-header, watchdog and reset sequences.
module tb_mine_job_scheduler;
   import mine_sched_pkg::*;

   localparam int HDR_W = 640;

   typedef struct {
      logic [1:0]  status;
      logic [31:0] nonce;
   } result_t;

   typedef struct {
      logic        useB;
      logic [31:0] startNonce;
      logic        findEn;
      logic [31:0] findOffset;
      logic [1:0]  expStatus;
      logic [31:0] expNonce;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   int          total = 0;
   int          bad = 0;
   result_t     sbA[$];
   result_t     sbB[$];
   logic        findEn;
   logic [31:0] findNonce;
   logic [31:0] nonceA;
   logic [31:0] nonceB;
   vec_t        vecs[6];

   always #5 clock = ~clock;

   mine_job_scheduler_if #(.HDR_W(HDR_W)) ifA ();
   mine_job_scheduler_if #(.HDR_W(HDR_W)) ifB ();

   mine_job_scheduler #(
      .HDR_W(HDR_W), .NONCE_SPAN(32'hFFFF_FFFF), .LOAD_CYCLES(2), .TIMEOUT_CYCLES(32'd100)
   ) dutA (.clock(clock), .reset(reset), .bus(ifA.master));

   mine_job_scheduler #(
      .HDR_W(HDR_W), .NONCE_SPAN(32'd4), .LOAD_CYCLES(2), .TIMEOUT_CYCLES(32'd100)
   ) dutB (.clock(clock), .reset(reset), .bus(ifB.master));

   // Behavioural miner cores: reload the start nonce in reset, count up in RUN.
   always @(posedge clock) begin
      nonceA <= ifA.core_reset ? ifA.core_header[31:0] : nonceA + 32'd1;
      nonceB <= ifB.core_reset ? ifB.core_header[31:0] : nonceB + 32'd1;
   end

   assign ifA.core_nonce = nonceA;
   assign ifB.core_nonce = nonceB;
   assign ifA.core_found = findEn && !ifA.core_reset && (nonceA == findNonce);
   assign ifB.core_found = findEn && !ifB.core_reset && (nonceB == findNonce);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkHdr(input string name, input logic [HDR_W-1:0] act, input logic [HDR_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got low word %0h expected low word %0h", name, act[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [HDR_W-1:0] mkHdr(input logic [31:0] startNonce);
      logic [HDR_W-1:0] h;
      h = '0;
      for (int i = 1; i < HDR_W / 32; i++) h[i*32 +: 32] = $urandom;
      h[31:0] = startNonce;
      return h;
   endfunction

   task automatic sampleOut(input logic useB, output logic req, output logic bsy,
                            output logic [1:0] st, output logic [31:0] nc,
                            output logic [HDR_W-1:0] hd);
      if (useB) begin
         req = ifB.tx_req; bsy = ifB.busy; st = ifB.tx_status; nc = ifB.tx_nonce; hd = ifB.core_header;
      end else begin
         req = ifA.tx_req; bsy = ifA.busy; st = ifA.tx_status; nc = ifA.tx_nonce; hd = ifA.core_header;
      end
   endtask

   task automatic sendHdr(input logic useB, input logic [HDR_W-1:0] hdr);
      if (useB) begin ifB.hdr_in = hdr; ifB.hdr_valid = 1'b1; end
      else begin ifA.hdr_in = hdr; ifA.hdr_valid = 1'b1; end
      @(negedge clock);
      ifA.hdr_valid = 1'b0;
      ifB.hdr_valid = 1'b0;
   endtask

   task automatic popCompare(input logic useB, input logic [1:0] st, input logic [31:0] nc);
      result_t exp;
      int      sz;
      sz = useB ? sbB.size() : sbA.size();
      check("sb_has_entry", 64'(sz > 0), 64'd1);
      if (sz > 0) begin
         exp = useB ? sbB.pop_front() : sbA.pop_front();
         check("tx_status", 64'(st), 64'(exp.status));
         check("tx_nonce", 64'(nc), 64'(exp.nonce));
      end
   endtask

   // Wait for a report, score it, acknowledge it.
   task automatic waitReport(input logic useB, input logic [HDR_W-1:0] hdr, input logic expBusyAfter);
      logic req, bsy;
      logic [1:0] st;
      logic [31:0] nc;
      logic [HDR_W-1:0] hd;
      int cyc;
      cyc = 0;
      sampleOut(useB, req, bsy, st, nc, hd);
      while (!req && cyc < 300) begin
         @(negedge clock);
         cyc++;
         sampleOut(useB, req, bsy, st, nc, hd);
      end
      check("report_wait", 64'(req), 64'd1);
      if (req) begin
         popCompare(useB, st, nc);
         checkHdr("core_header_report", hd, hdr);
         check("busy_report", 64'(bsy), 64'd1);
         if (useB) ifB.tx_ack = 1'b1; else ifA.tx_ack = 1'b1;
         @(negedge clock);
         ifA.tx_ack = 1'b0;
         ifB.tx_ack = 1'b0;
         sampleOut(useB, req, bsy, st, nc, hd);
         check("tx_req_after_ack", 64'(req), 64'd0);
         check("busy_after_ack", 64'(bsy), 64'(expBusyAfter));
      end
   endtask

   task automatic runJob(input vec_t v);
      logic [HDR_W-1:0] hdr;
      result_t exp;
      logic req, bsy;
      logic [1:0] st;
      logic [31:0] nc;
      logic [HDR_W-1:0] hd;
      hdr = mkHdr(v.startNonce);
      findEn = v.findEn;
      findNonce = v.startNonce + v.findOffset;
      exp.status = v.expStatus;
      exp.nonce = v.expNonce;
      if (v.useB) sbB.push_back(exp); else sbA.push_back(exp);
      sendHdr(v.useB, hdr);
      waitReport(v.useB, hdr, 1'b0);
      sampleOut(v.useB, req, bsy, st, nc, hd);
      check("status_held_idle", 64'(st), 64'(v.expStatus));
   endtask

   initial begin
      logic [HDR_W-1:0] h1, h2, h3, h4, h5, h6, h7, h8;
      int cyc;

      reset = 1'b1;
      findEn = 1'b0;
      findNonce = 32'd0;
      ifA.hdr_valid = 1'b0; ifA.hdr_in = '0; ifA.tx_ack = 1'b0;
      ifB.hdr_valid = 1'b0; ifB.hdr_in = '0; ifB.tx_ack = 1'b0;

      vecs[0] = '{1'b0, 32'h42a1_4690, 1'b1, 32'd5, 2'b01, 32'h42a1_4695};
      vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 32'd0, 2'b01, 32'h0000_0000};
      vecs[2] = '{1'b0, 32'hFFFF_FFFD, 1'b1, 32'd3, 2'b01, 32'h0000_0000};
      vecs[3] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0, 2'b10, 32'h0000_0002};
      vecs[4] = '{1'b1, 32'h0000_0010, 1'b1, 32'd4, 2'b01, 32'h0000_0014};
      vecs[5] = '{1'b1, 32'h0000_0100, 1'b1, 32'd7, 2'b10, 32'h0000_0104};

      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Reset state
      check("rst_core_reset", 64'(ifA.core_reset), 64'd1);
      check("rst_tx_req", 64'(ifA.tx_req), 64'd0);
      check("rst_busy", 64'(ifA.busy), 64'd0);
      check("rst_tx_status", 64'(ifA.tx_status), 64'd0);
      check("rst_tx_nonce", 64'(ifA.tx_nonce), 64'd0);
      checkHdr("rst_core_header", ifA.core_header, '0);

      // Ack outside REPORT is ignored
      ifA.tx_ack = 1'b1;
      @(negedge clock);
      ifA.tx_ack = 1'b0;
      check("idle_ack_busy", 64'(ifA.busy), 64'd0);
      check("idle_ack_req", 64'(ifA.tx_req), 64'd0);

      // LOAD timing, then preemption 10 cycles into RUN
      h1 = mkHdr(32'h1000_0000);
      findEn = 1'b1;
      findNonce = 32'h1000_4000;
      sendHdr(1'b0, h1);
      check("load_c1_core_reset", 64'(ifA.core_reset), 64'd1);
      check("load_c1_busy", 64'(ifA.busy), 64'd1);
      checkHdr("load_header", ifA.core_header, h1);
      @(negedge clock);
      check("load_c2_core_reset", 64'(ifA.core_reset), 64'd1);
      @(negedge clock);
      check("run_core_reset", 64'(ifA.core_reset), 64'd0);
      repeat (9) @(negedge clock);
      check("run_no_req", 64'(ifA.tx_req), 64'd0);
      h2 = mkHdr(32'h2000_0000);
      findNonce = 32'h2000_0002;
      sbA.push_back('{2'b01, 32'h2000_0002});
      sendHdr(1'b0, h2);
      check("preempt_c1_core_reset", 64'(ifA.core_reset), 64'd1);
      check("preempt_c1_req", 64'(ifA.tx_req), 64'd0);
      @(negedge clock);
      check("preempt_c2_core_reset", 64'(ifA.core_reset), 64'd1);
      check("preempt_c2_req", 64'(ifA.tx_req), 64'd0);
      @(negedge clock);
      check("preempt_run_core_reset", 64'(ifA.core_reset), 64'd0);
      checkHdr("preempt_header", ifA.core_header, h2);
      waitReport(1'b0, h2, 1'b0);

      // Vector table
      for (int i = 0; i < 6; i++) runJob(vecs[i]);

      // Header and result on the same edge, then overwrite of the pending header
      h3 = mkHdr(32'h3000_0000);
      findEn = 1'b1;
      findNonce = 32'h3000_0004;
      sbA.push_back('{2'b01, 32'h3000_0004});
      sendHdr(1'b0, h3);
      cyc = 0;
      while (!ifA.core_found && cyc < 50) begin
         @(negedge clock);
         cyc++;
      end
      check("sim_found_seen", 64'(ifA.core_found), 64'd1);
      h4 = mkHdr(32'h4000_0000);
      sendHdr(1'b0, h4);
      check("sim_req", 64'(ifA.tx_req), 64'd1);
      popCompare(1'b0, ifA.tx_status, ifA.tx_nonce);
      h5 = mkHdr(32'h5000_0000);
      sendHdr(1'b0, h5);
      check("sim_req_held", 64'(ifA.tx_req), 64'd1);
      check("sim_status_held", 64'(ifA.tx_status), 64'd1);
      check("sim_nonce_held", 64'(ifA.tx_nonce), 64'h3000_0004);
      findNonce = 32'h5000_0001;
      sbA.push_back('{2'b01, 32'h5000_0001});
      ifA.tx_ack = 1'b1;
      @(negedge clock);
      ifA.tx_ack = 1'b0;
      check("pend_req", 64'(ifA.tx_req), 64'd0);
      check("pend_busy", 64'(ifA.busy), 64'd1);
      check("pend_core_reset", 64'(ifA.core_reset), 64'd1);
      checkHdr("pend_header", ifA.core_header, h5);
      @(negedge clock);
      check("pend_c2_core_reset", 64'(ifA.core_reset), 64'd1);
      @(negedge clock);
      check("pend_run_core_reset", 64'(ifA.core_reset), 64'd0);
      waitReport(1'b0, h5, 1'b0);

      // Watchdog: no find at all
      h6 = mkHdr(32'h6000_0000);
      findEn = 1'b0;
`ifdef MINE_WATCHDOG_EN
      sbA.push_back('{2'b11, 32'h6000_0063});
      sendHdr(1'b0, h6);
      cyc = 0;
      while (ifA.core_reset && cyc < 10) begin
         @(negedge clock);
         cyc++;
      end
      cyc = 0;
      while (!ifA.tx_req && cyc < 300) begin
         @(negedge clock);
         cyc++;
      end
      check("wd_run_cycles", 64'(cyc), 64'd100);
      waitReport(1'b0, h6, 1'b0);
`else
      sendHdr(1'b0, h6);
      repeat (150) @(negedge clock);
      check("nowd_no_req", 64'(ifA.tx_req), 64'd0);
      check("nowd_busy", 64'(ifA.busy), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
`endif

      // Reset while reporting, with a header pending
      h7 = mkHdr(32'h7000_0000);
      findEn = 1'b1;
      findNonce = 32'h7000_0002;
      sbA.push_back('{2'b01, 32'h7000_0002});
      sendHdr(1'b0, h7);
      cyc = 0;
      while (!ifA.tx_req && cyc < 50) begin
         @(negedge clock);
         cyc++;
      end
      check("rr_req", 64'(ifA.tx_req), 64'd1);
      popCompare(1'b0, ifA.tx_status, ifA.tx_nonce);
      h8 = mkHdr(32'h8000_0000);
      sendHdr(1'b0, h8);
      #2 reset = 1'b1;
      #1;
      check("rr_async_req", 64'(ifA.tx_req), 64'd0);
      check("rr_async_core_reset", 64'(ifA.core_reset), 64'd1);
      check("rr_async_status", 64'(ifA.tx_status), 64'd0);
      check("rr_async_nonce", 64'(ifA.tx_nonce), 64'd0);
      check("rr_async_busy", 64'(ifA.busy), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      check("rr_pending_dropped_busy", 64'(ifA.busy), 64'd0);
      check("rr_pending_dropped_core_reset", 64'(ifA.core_reset), 64'd1);

      check("sbA_empty", 64'(sbA.size()), 64'd0);
      check("sbB_empty", 64'(sbB.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mine_job_scheduler.md
# mine_job_scheduler

Sequences the SHA-256 mining core for one block-header job at a time. It accepts a 640-bit header from the serial receive path and holds the miner core in reset while loading it. It then supervises the nonce search until the core reports success, the nonce span is exhausted or a watchdog expires, and hands a one-word result to the serial transmit path through a request/acknowledge handshake. It sits between the UART core and the miner control block, replacing ad-hoc reset/send glue in the top level.

## Interface
Parameters:
- HDR_W, 640, block-header width; bits [31:0] hold the starting nonce
- NONCE_SPAN, 32'hFFFF_FFFF, number of nonces to try after the start nonce before declaring exhaustion
- LOAD_CYCLES, 2, cycles core_reset is held high in LOAD (≥1)
- TIMEOUT_CYCLES, 32'd50_000_000, RUN-state watchdog limit (used only with the watchdog macro)

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high; returns the block to IDLE
- hdr_valid  in  1  one-cycle pulse, new header on hdr_in
- hdr_in  in  HDR_W  header from UART receive path
- core_reset  out  1  reset to miner core; high unless in RUN
- core_header  out  HDR_W  latched job header
- core_nonce  in  32  nonce currently being hashed by the core
- core_found  in  1  level; the core's current nonce meets target
- tx_req  out  1  result ready; held until tx_ack
- tx_ack  in  1  one-cycle acknowledge from transmit path
- tx_nonce  out  32  reported nonce
- tx_status  out  2  00 none, 01 FOUND, 10 EXHAUSTED, 11 TIMEOUT
- busy  out  1  high in LOAD, RUN or REPORT

## Operation
- States: IDLE, LOAD, RUN, REPORT.
- Reset values:
  - state IDLE
  - core_reset 1
  - core_header 0
  - tx_req 0
  - tx_nonce 0
  - tx_status 00
  - busy 0
  - pending flag 0
- IDLE: on hdr_valid, latch hdr_in into core_header, compute last_nonce = hdr_in[31:0] + NONCE_SPAN (mod 2^32, wraps), then go to LOAD.
- LOAD: core_reset high for LOAD_CYCLES, then go to RUN.
- RUN: core_reset low. Events are checked in priority order:
  - core_found: tx_nonce ← core_nonce, status FOUND.
  - core_nonce == last_nonce: tx_nonce ← last_nonce, status EXHAUSTED.
  - watchdog expiry: status TIMEOUT, tx_nonce ← core_nonce.
  - Any of the three moves to REPORT.
- hdr_valid in RUN with no result event that cycle: abort the job, latch the new header and last_nonce, return to LOAD. No report is produced for the aborted job.
- hdr_valid in the same cycle as a RUN result event: the result wins and the header is stored in a one-deep pending buffer.
- REPORT: tx_req high, tx_nonce and tx_status stable.
  - hdr_valid here goes to the pending buffer; a newer header overwrites an older one.
  - On tx_ack: go to LOAD if pending (pending header becomes core_header, pending cleared), else IDLE.
- tx_ack outside REPORT is ignored.
- tx_status and tx_nonce keep their last value until the next report.

## Timing
- hdr_valid sampled in IDLE at edge N:
  - LOAD from N+1.
  - core_reset high through N+LOAD_CYCLES.
  - RUN, with core_reset low, from N+LOAD_CYCLES+1.
- core_found sampled high in RUN at edge M: tx_req high and tx_nonce valid after edge M (one-cycle latency).
- tx_ack at edge K: tx_req low after K; busy low after K if no pending header.
- Reset asserted mid-job: all outputs take their reset values immediately (asynchronously), and the pending header is discarded.

## Configuration
- MINE_WATCHDOG_EN defined:
  - 32-bit counter clears on RUN entry and increments each RUN cycle.
  - Reaching TIMEOUT_CYCLES-1 raises the TIMEOUT event.
- MINE_WATCHDOG_EN undefined:
  - No counter is built; TIMEOUT is never reported.
  - A job ends only on FOUND, EXHAUSTED, abort or reset.

## Structure
- Package mine_sched_pkg holds:
  - state encoding (IDLE=0, LOAD=1, RUN=2, REPORT=3)
  - status codes
  - nonce width constant 32
- One sub-module: mine_watchdog (enable, clear, terminal-count pulse), instantiated only under MINE_WATCHDOG_EN.

## Test plan
- Basic find: header nonce 32'h42a1_4690, core_nonce counts up, core_found asserted at 32'h42a1_4695 → tx_req=1, tx_nonce=32'h42a1_4695, tx_status=01; tx_ack → IDLE, busy=0.
- Exhaustion with wrap: NONCE_SPAN=4, start nonce 32'hFFFF_FFFE, core steps FFFF_FFFE…0000_0002 with no find → status 10, tx_nonce=32'h0000_0002.
- Preemption: second hdr_valid 10 cycles into RUN → no tx_req; core_reset high for LOAD_CYCLES; core_header equals the new header.
- Simultaneous events: hdr_valid and core_found on the same edge → FOUND reported; after tx_ack, LOAD entered with the pending header; a third header sent during REPORT overwrites the pending one.
- Watchdog (MINE_WATCHDOG_EN, TIMEOUT_CYCLES=100): no find → tx_status=11 exactly 100 RUN cycles after RUN entry; rebuild without the macro → no report.
- Reset mid-REPORT: reset asserted while tx_req=1 → tx_req=0, core_reset=1, tx_status=00 without waiting for a clock edge.
